// File: rtl/pridecode4_16.sv
// 4-to-16 one-hot decoder with valid/ready handshake; each decoded word is
// held for HOLD cycles and followed by a single GAP cycle.
//
// state | meaning
// IDLE  | waiting for a code, in_ready high unless flush
// DRIVE | one-hot word on out, counting down HOLD cycles
// GAP   | out cleared for one cycle before returning to IDLE
module pridecode4_16 #(
    parameter int HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  i,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] out,
    output logic        out_valid,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

    logic [1:0] state;
    logic [7:0] cnt;

    assign in_ready = (state == IDLE) && !flush;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out       <= 16'h0000;
            out_valid <= 1'b0;
            cnt       <= 8'd0;
        end else if (flush) begin
            state     <= IDLE;
            out       <= 16'h0000;
            out_valid <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= DRIVE;
                        out       <= 16'b1 << i;
                        out_valid <= 1'b1;
                        cnt       <= HOLD_LOAD;
                    end
                end
                DRIVE: begin
                    if (cnt == 8'd0) begin
                        state     <= GAP;
                        out       <= 16'h0000;
                        out_valid <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    out       <= 16'h0000;
                    out_valid <= 1'b0;
                    cnt       <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pridecode4_16.sv
// Bench for pridecode4_16: four instances (HOLD = 1, 2, 4, 8) share clk, rst,
// i and flush; a negedge monitor checks every presented word against a queue.
module tb_pridecode4_16;

    localparam int HOLDS [4] = '{1, 2, 4, 8};

    typedef struct {
        int          inst;
        logic [15:0] word;
        int          len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i = 4'h0;
    logic        flush = 1'b0;
    logic        in_valid_w [4];
    logic        in_ready_w [4];
    logic [15:0] out_w [4];
    logic        ov_w [4];
    logic        busy_w [4];

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        pridecode4_16 #(.HOLD(HOLDS[g])) u_dut (
            .clk      (clk),
            .rst      (rst),
            .i        (i),
            .in_valid (in_valid_w[g]),
            .in_ready (in_ready_w[g]),
            .flush    (flush),
            .out      (out_w[g]),
            .out_valid(ov_w[g]),
            .busy     (busy_w[g])
        );
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor state
    logic [15:0] cur_w [4];
    int          run [4];
    int          exp_len [4];
    logic        prev_ov [4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            cur_w[k] = 16'h0;
            run[k] = 0;
            exp_len[k] = -1;
            prev_ov[k] = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (ov_w[k]) begin
                if (!prev_ov[k]) begin
                    if (q.size() == 0) begin
                        chk(1'b0, "unexpected_word", {16'h0, out_w[k]}, 32'h0);
                        cur_w[k] = out_w[k];
                        exp_len[k] = -1;
                    end else begin
                        e = q.pop_front();
                        chk(e.inst == k, "word_instance", k, e.inst);
                        cur_w[k] = e.word;
                        exp_len[k] = e.len;
                    end
                    run[k] = 1;
                end else begin
                    run[k]++;
                end
                chk(out_w[k] == cur_w[k], "word_value", {16'h0, out_w[k]}, {16'h0, cur_w[k]});
                chk($onehot(out_w[k]), "word_onehot", {16'h0, out_w[k]}, {16'h0, cur_w[k]});
            end else begin
                if (prev_ov[k] && exp_len[k] >= 0)
                    chk(run[k] == exp_len[k], "word_length", run[k], exp_len[k]);
                chk(out_w[k] == 16'h0, "idle_out_zero", {16'h0, out_w[k]}, 32'h0);
            end
            prev_ov[k] = ov_w[k];
        end
    end

    initial begin
        logic [3:0] seq [12];
        seq = '{4'h3, 4'h7, 4'h1, 4'h9, 4'hA, 4'h2, 4'h4, 4'h6, 4'hC, 4'hE, 4'h5, 4'hB};
        for (int k = 0; k < 4; k++) in_valid_w[k] = 1'b0;

        // reset state
        #2;
        for (int k = 0; k < 4; k++) begin
            chk(out_w[k] == 16'h0, "rst_out", {16'h0, out_w[k]}, 32'h0);
            chk(ov_w[k] == 1'b0, "rst_out_valid", ov_w[k], 0);
            chk(busy_w[k] == 1'b0, "rst_busy", busy_w[k], 0);
            chk(in_ready_w[k] == 1'b1, "rst_in_ready", in_ready_w[k], 1);
        end
        flush = 1'b1;
        #1 chk(in_ready_w[0] == 1'b0, "rst_flush_in_ready", in_ready_w[0], 0);
        flush = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // HOLD=1, i=5
        i = 4'h5;
        in_valid_w[0] = 1'b1;
        q.push_back('{0, 16'h0020, 1});
        tick();
        in_valid_w[0] = 1'b0;
        chk(out_w[0] == 16'h0020, "h1_out", {16'h0, out_w[0]}, 32'h0020);
        chk(ov_w[0] == 1'b1, "h1_valid", ov_w[0], 1);
        chk(in_ready_w[0] == 1'b0, "h1_ready_drive", in_ready_w[0], 0);
        tick();
        chk(out_w[0] == 16'h0, "h1_gap_out", {16'h0, out_w[0]}, 32'h0);
        chk(busy_w[0] == 1'b1, "h1_gap_busy", busy_w[0], 1);
        chk(in_ready_w[0] == 1'b0, "h1_gap_ready", in_ready_w[0], 0);
        tick();
        chk(in_ready_w[0] == 1'b1, "h1_idle_ready", in_ready_w[0], 1);
        chk(busy_w[0] == 1'b0, "h1_idle_busy", busy_w[0], 0);

        // HOLD=4, i=F
        i = 4'hF;
        in_valid_w[2] = 1'b1;
        q.push_back('{2, 16'h8000, 4});
        tick();
        in_valid_w[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk(out_w[2] == ((k < 4) ? 16'h8000 : 16'h0000), "h4_out", {16'h0, out_w[2]},
                (k < 4) ? 32'h8000 : 32'h0);
            chk(busy_w[2] == (k < 5), "h4_busy", busy_w[2], (k < 5));
            tick();
        end

        // HOLD=2, in_valid held with i changing every cycle: accepts 3, A, C
        q.push_back('{1, 16'h0008, 2});
        q.push_back('{1, 16'h0400, 2});
        q.push_back('{1, 16'h1000, 2});
        in_valid_w[1] = 1'b1;
        for (int n = 0; n < 12; n++) begin
            i = seq[n];
            #0 chk(in_ready_w[1] == ((n % 4) == 0), "h2_stream_ready", in_ready_w[1], ((n % 4) == 0));
            tick();
        end
        in_valid_w[1] = 1'b0;
        repeat (3) tick();

        // HOLD=8, flush in the 2nd DRIVE cycle
        i = 4'h6;
        in_valid_w[3] = 1'b1;
        q.push_back('{3, 16'h0040, 2});
        tick();
        in_valid_w[3] = 1'b0;
        tick();
        flush = 1'b1;
        in_valid_w[3] = 1'b1;
        i = 4'h2;
        tick();
        chk(out_w[3] == 16'h0, "flush_out", {16'h0, out_w[3]}, 32'h0);
        chk(ov_w[3] == 1'b0, "flush_valid", ov_w[3], 0);
        chk(busy_w[3] == 1'b0, "flush_idle", busy_w[3], 0);
        tick();
        chk(busy_w[3] == 1'b0, "flush_no_accept", busy_w[3], 0);
        flush = 1'b0;
        in_valid_w[3] = 1'b0;
        #0 chk(in_ready_w[3] == 1'b1, "flush_release_ready", in_ready_w[3], 1);
        tick();

        // HOLD=8, async reset while out=0001, then i=3 right after release
        i = 4'h0;
        in_valid_w[3] = 1'b1;
        tick();
        in_valid_w[3] = 1'b0;
        chk(out_w[3] == 16'h0001, "arst_pre_out", {16'h0, out_w[3]}, 32'h0001);
        #1 rst = 1'b1;
        #1;
        chk(out_w[3] == 16'h0, "arst_out", {16'h0, out_w[3]}, 32'h0);
        chk(ov_w[3] == 1'b0, "arst_valid", ov_w[3], 0);
        chk(busy_w[3] == 1'b0, "arst_busy", busy_w[3], 0);
        chk(in_ready_w[3] == 1'b1, "arst_ready", in_ready_w[3], 1);
        rst = 1'b0;
        i = 4'h3;
        in_valid_w[3] = 1'b1;
        q.push_back('{3, 16'h0008, 8});
        tick();
        in_valid_w[3] = 1'b0;
        chk(out_w[3] == 16'h0008, "arst_first_accept", {16'h0, out_w[3]}, 32'h0008);
        repeat (10) tick();

        // HOLD=1 sweep of all codes at minimum spacing
        for (int c = 0; c < 16; c++) begin
            i = 4'(c);
            in_valid_w[0] = 1'b1;
            #0 chk(in_ready_w[0] == 1'b1, "sweep_ready", in_ready_w[0], 1);
            q.push_back('{0, 16'(32'h1 << c), 1});
            tick();
            in_valid_w[0] = 1'b0;
            chk(out_w[0] == 16'(32'h1 << c), "sweep_out", {16'h0, out_w[0]}, 32'h1 << c);
            repeat (2) tick();
        end
        repeat (4) tick();

        chk(q.size() == 0, "words_outstanding", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
